// File: rtl/instruction_fetch_pkg.sv
// Shared core types and constants for the instruction fetch stage.
// Imported by the fetch top level and its instruction buffer.
package instruction_fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Registered instruction buffer holding {instruction, pc} pairs between memory and decode.
// Flush wins over push so a redirect can never leave a stale entry behind.
module fetch_fifo
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  logic [ILEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CW-1:0]   count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign instr_o = mem_q[rd_q].instr;
    assign pc_o    = mem_q[rd_q].pc;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush_i) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push && !flush_i) begin
            mem_q[wr_q] <= '{instr: instr_i, pc: pc_i};
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: single-outstanding memory requester feeding a decode buffer.
// Redirects flush the buffer and, if a response is still in flight, drop it in FLUSH.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [ILEN-1:0] instruction,
    output logic [XLEN-1:0] instr_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] tag_q, tag_d;

    logic            push, pop;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [ILEN-1:0] head_instr;
    logic [XLEN-1:0] head_pc;

    logic            waiting, rsp_in_wait, may_request;
    logic            req_en, req_fire;
    logic [31:0]     occ_after;

    assign waiting     = (state_q == WAIT);
    assign rsp_in_wait = waiting && imem_rsp_valid;

    assign instr_valid = !fifo_empty && !redirect_valid;
    assign pop         = instr_valid && instr_ready;
    assign push        = rsp_in_wait && !redirect_valid;

    // The in-flight request already owns a buffer slot; a new one may only go
    // out if every response, including this one, still fits after this pop.
    assign occ_after   = 32'(fifo_count) + 32'(waiting) - 32'(pop);
    assign may_request = (state_q == FETCH) || rsp_in_wait;
    assign req_en      = rst_n && !redirect_valid && may_request &&
                         (occ_after < 32'(FIFO_DEPTH));
    assign req_fire    = req_en && imem_req_ready;

    assign imem_req_valid = req_en;
    assign imem_req_addr  = rst_n ? pc_q : '0;
    assign instruction    = head_instr;
    assign instr_pc       = head_pc;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tag_d   = tag_q;
        if (redirect_valid) begin
            pc_d = word_align(redirect_pc);
            // A response still owed to the old stream must be swallowed later.
            if ((state_q != FETCH) && !imem_rsp_valid) state_d = FLUSH;
            else                                       state_d = FETCH;
        end else begin
            case (state_q)
                FETCH:   if (req_fire) state_d = WAIT;
                WAIT:    if (imem_rsp_valid) state_d = req_fire ? WAIT : FETCH;
                FLUSH:   if (imem_rsp_valid) state_d = FETCH;
                default: state_d = FETCH;
            endcase
            if (req_fire) begin
                pc_d  = pc_q + 32'd4;
                tag_d = pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tag_q   <= tag_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .instr_i (imem_rsp_data),
        .pc_i    (tag_q),
        .instr_o (head_instr),
        .pc_o    (head_pc),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (!rst_n) !(push && fifo_full)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: randomized memory/decoder/redirect traffic
// checked against an address-stream model, plus directed fetch scenarios.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instruction, instr_pc;

    instruction_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];          // pcs the decoder must see next, in order
    logic [31:0] stream_pc;         // next pc of the architectural stream
    logic [31:0] req_exp;           // next address the fetcher should request
    bit          outst;             // memory model: a request is in flight
    int          mcnt;
    logic [31:0] maddr;
    bit          prev_hold;
    logic [31:0] prev_addr;
    int          stall;
    bit          s_rv, s_fire, s_iv, s_pop;
    logic [31:0] s_ra, s_ipc, s_ins;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: every accepted instruction must be the next one of the stream.
    always @(negedge clk) begin
        #2;
        if (rst_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                logic [31:0] epc;
                epc = exp_q.pop_front();
                chk("sb_instr_pc", instr_pc, epc);
                chk("sb_instruction", instruction, memf(epc));
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        exp_q.delete();
        stream_pc = 32'h0; req_exp = 32'h0;
        outst = 1'b0; mcnt = 0; prev_hold = 1'b0; stall = 0;
        @(negedge clk); #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'd0);
        chk("rst_instruction", instruction, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle, starting and ending at a falling edge.
    task automatic step(input bit rdy, input bit irdy, input int lat,
                        input bit redir = 1'b0, input logic [31:0] rpc = 32'h0,
                        input bit stale = 1'b0);
        bit rsp_now;
        imem_req_ready = rdy;
        instr_ready    = irdy;
        redirect_valid = redir;
        redirect_pc    = redir ? rpc : $urandom;
        rsp_now        = outst && (mcnt == 0);
        imem_rsp_valid = rsp_now || stale;
        imem_rsp_data  = rsp_now ? memf(maddr) : (stale ? memf(32'h0) ^ 32'hDEAD_BEEF : $urandom);
        if (redir) begin
            exp_q.delete();
            stream_pc = rpc & ~32'h3;
            req_exp   = stream_pc;
        end
        #1;
        s_rv = imem_req_valid; s_ra = imem_req_addr;
        s_iv = instr_valid; s_ipc = instr_pc; s_ins = instruction;
        s_fire = s_rv && rdy;
        s_pop  = s_iv && irdy;
        while (exp_q.size() < 4) begin
            exp_q.push_back(stream_pc);
            stream_pc += 32'd4;
        end
        if (redir) begin
            chk("req_valid_in_redirect", 32'(s_rv), 32'd0);
            chk("instr_valid_in_redirect", 32'(s_iv), 32'd0);
        end
        if (s_fire) begin
            chk("single_outstanding", 32'(outst && !rsp_now), 32'd0);
            chk("req_addr", s_ra, req_exp);
            req_exp += 32'd4;
        end
        if (s_rv && prev_hold) chk("req_addr_stable", s_ra, prev_addr);
        prev_hold = s_rv && !rdy;
        prev_addr = s_ra;
        if (irdy) begin
            if (s_pop || redir) stall = 0;
            else stall++;
            if (stall > 30) begin
                chk("fetch_stall", 32'(stall), 32'd0);
                stall = 0;
            end
        end
        if (rsp_now) outst = 1'b0;
        else if (outst) mcnt--;
        if (s_fire) begin
            outst = 1'b1; maddr = s_ra; mcnt = lat - 1;
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got_req, got_ins;
        int fires;

        // Streaming at full rate from reset.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b1, 1);
            if (k < 3) begin
                chk("a_req_valid", 32'(s_rv), 32'd1);
                chk("a_req_addr", s_ra, 32'(4 * k));
            end
            if (k == 1) chk("a_no_early_instr", 32'(s_iv), 32'd0);
            if (k >= 2) begin
                chk("a_instr_valid", 32'(s_iv), 32'd1);
                chk("a_instr_pc", s_ipc, 32'(4 * (k - 2)));
            end
        end

        // Decoder stalled: buffer fills to depth and fetching stops.
        do_reset();
        fires = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 1'b0, 1);
            fires += int'(s_fire);
        end
        chk("b_fire_count", 32'(fires), 32'd2);
        chk("b_no_request", 32'(s_rv), 32'd0);
        chk("b_head_valid", 32'(s_iv), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1);
            chk("b_drain_valid", 32'(s_iv), 32'd1);
            chk("b_drain_pc", s_ipc, 32'(4 * k));
        end

        // Redirect while the request to 0x8 is outstanding.
        do_reset();
        step(1'b1, 1'b1, 1);
        step(1'b1, 1'b1, 1);
        step(1'b1, 1'b1, 4);
        chk("c_req8_fire", 32'(s_fire), 32'd1);
        chk("c_req8_addr", s_ra, 32'h8);
        step(1'b1, 1'b1, 1, 1'b1, 32'h103);
        got_req = 1'b0; got_ins = 1'b0;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b1, 1);
            if (s_fire && !got_req) begin chk("c_first_req", s_ra, 32'h100); got_req = 1'b1; end
            if (s_iv && !got_ins) begin chk("c_first_pc", s_ipc, 32'h100); got_ins = 1'b1; end
        end
        chk("c_req_seen", 32'(got_req), 32'd1);
        chk("c_instr_seen", 32'(got_ins), 32'd1);

        // Redirect coinciding with a response: that data must vanish.
        do_reset();
        step(1'b1, 1'b1, 1);
        step(1'b1, 1'b1, 1, 1'b1, 32'h200);
        got_ins = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b1, 1);
            if (s_iv && !got_ins) begin
                chk("d_first_pc", s_ipc, 32'h200);
                chk("d_first_instr", s_ins, memf(32'h200));
                got_ins = 1'b1;
            end
        end
        chk("d_instr_seen", 32'(got_ins), 32'd1);

        // Memory not ready (with a stray response right after reset).
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1, 1'b0, 32'h0, k == 0);
            chk("e_hold_valid", 32'(s_rv), 32'd1);
            chk("e_hold_addr", s_ra, 32'h0);
        end
        step(1'b1, 1'b1, 1);
        chk("e_accept_addr", s_ra, 32'h0);
        step(1'b1, 1'b1, 1);
        chk("e_next_addr", s_ra, 32'h4);

        // PC wraps past the top of the address space.
        do_reset();
        step(1'b0, 1'b1, 1, 1'b1, 32'hFFFF_FFFE);
        step(1'b1, 1'b1, 1);
        chk("f_top_addr", s_ra, 32'hFFFF_FFFC);
        step(1'b1, 1'b1, 1);
        chk("f_wrap_addr", s_ra, 32'h0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1);

        // Randomized traffic with occasional redirects and resets.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                step(1'b0, 1'b1, 1, 1'b0, 32'h0, 1'b1);
            end else begin
                step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                     int'($urandom_range(1, 3)), $urandom_range(0, 99) < 3, $urandom);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
